// File: rtl/q100_wb_arb.sv
// q100_wb_arb: multi-channel writeback stage, per-channel FIFOs arbitrated round-robin onto one RF/CSR write port
module q100_wb_arb #(
    parameter  int N_CH   = 2,
    parameter  int XLEN   = 32,
    parameter  int NREG   = 32,
    parameter  int CSR_AW = 12,
    parameter  int DEPTH  = 2,
    localparam int RD_W   = $clog2(NREG),
    localparam int GW     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int PW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [N_CH-1:0]          ch_vld_i,
    output logic [N_CH-1:0]          ch_rdy_o,
    input  logic [N_CH-1:0]          ch_wb_i,
    input  logic [N_CH*RD_W-1:0]     ch_rd_i,
    input  logic [N_CH*XLEN-1:0]     ch_data_i,
    input  logic [N_CH-1:0]          ch_csr_i,
    input  logic [N_CH*CSR_AW-1:0]   ch_csr_addr_i,
    input  logic [N_CH*XLEN-1:0]     ch_csr_val_i,
    output logic [XLEN-1:0]          xn_result_o,
    output logic [NREG-1:0]          xn_wr_en_o,
    output logic                     reg_wr_o,
    output logic [RD_W-1:0]          rd_o,
    output logic                     csr_vld_o,
    output logic [CSR_AW-1:0]        csr_addr_o,
    output logic [XLEN-1:0]          csr_value_o,
    output logic [GW-1:0]            grant_ch_o,
    output logic                     busy_o
);

    typedef struct packed {
        logic              wb;
        logic [RD_W-1:0]   rd;
        logic [XLEN-1:0]   data;
        logic              csr;
        logic [CSR_AW-1:0] addr;
        logic [XLEN-1:0]   val;
    } ent_t;

    ent_t            mem [N_CH][DEPTH];
    ent_t            ch_in [N_CH];
    ent_t            head;
    logic [PW:0]     cnt [N_CH];
    logic [PW-1:0]   wp [N_CH];
    logic [PW-1:0]   rp [N_CH];
    logic [N_CH-1:0] push;
    logic [N_CH-1:0] pop;
    logic [GW-1:0]   rr;
    logic [GW-1:0]   gnt;
    logic            req;
    logic            pop_any;
    logic            head_wr;

    // Unpack the flattened channel buses and derive the handshake per channel
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            ch_in[c]    = '{ch_wb_i[c], ch_rd_i[c*RD_W +: RD_W], ch_data_i[c*XLEN +: XLEN],
                            ch_csr_i[c], ch_csr_addr_i[c*CSR_AW +: CSR_AW], ch_csr_val_i[c*XLEN +: XLEN]};
            ch_rdy_o[c] = (cnt[c] != (PW+1)'(DEPTH)) && !flush_i;
            push[c]     = ch_vld_i[c] && ch_rdy_o[c];
            pop[c]      = pop_any && (int'(gnt) == c);
        end
    end

    // Round-robin search: walking downwards leaves the closest non-empty channel at or after rr
    always_comb begin
        gnt = '0;
        req = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cnt[(int'(rr) + k) % N_CH] != '0) begin
                req = 1'b1;
                gnt = GW'((int'(rr) + k) % N_CH);
            end
        end
    end

    assign pop_any = req && !flush_i;
    assign head    = mem[gnt][rp[gnt]];
    assign head_wr = head.wb && (head.rd != '0);

    // FIFO payload storage; contents are meaningless while the count says empty, so no reset
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++)
            if (push[c]) mem[c][wp[c]] <= ch_in[c];
    end

    // FIFO pointers and occupancy; flush empties every channel at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt[c] <= '0;
                wp[c]  <= '0;
                rp[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (flush_i) begin
                    cnt[c] <= '0;
                    wp[c]  <= '0;
                    rp[c]  <= '0;
                end else begin
                    if (push[c]) wp[c] <= wp[c] + 1'b1;
                    if (pop[c]) rp[c] <= rp[c] + 1'b1;
                    cnt[c] <= cnt[c] + (PW+1)'(push[c]) - (PW+1)'(pop[c]);
                end
            end
        end
    end

    // Output register and rr pointer: a popped head becomes a one-cycle pulse, otherwise all zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= '0;
            reg_wr_o    <= 1'b0;
            xn_wr_en_o  <= '0;
            xn_result_o <= '0;
            rd_o        <= '0;
            csr_vld_o   <= 1'b0;
            csr_addr_o  <= '0;
            csr_value_o <= '0;
            grant_ch_o  <= '0;
        end else begin
            if (pop_any) rr <= (int'(gnt) == N_CH - 1) ? '0 : gnt + 1'b1;
            reg_wr_o    <= pop_any && head_wr;
            xn_wr_en_o  <= (pop_any && head_wr) ? NREG'(1) << head.rd : '0;
            xn_result_o <= pop_any ? head.data : '0;
            rd_o        <= pop_any ? head.rd : '0;
            csr_vld_o   <= pop_any && head.csr;
            csr_addr_o  <= (pop_any && head.csr) ? head.addr : '0;
            csr_value_o <= (pop_any && head.csr) ? head.val : '0;
            grant_ch_o  <= pop_any ? gnt : '0;
        end
    end

    // Busy while anything is buffered or a write pulse is on the outputs
    always_comb begin
        busy_o = reg_wr_o || csr_vld_o;
        for (int c = 0; c < N_CH; c++)
            busy_o = busy_o || (cnt[c] != '0);
    end

endmodule

// File: tb/tb_q100_wb_arb.sv
// tb_q100_wb_arb: randomized and directed checks of q100_wb_arb against a queue-based reference model
module tb_q100_wb_arb;
    localparam int N = 2, XLEN = 32, NREG = 32, AW = 12, DEPTH = 2, RW = 5;

    typedef struct {
        bit            wb;
        bit [RW-1:0]   rd;
        bit [XLEN-1:0] data;
        bit            csr;
        bit [AW-1:0]   a;
        bit [XLEN-1:0] v;
    } ent_t;

    logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [N-1:0]      ch_vld = '0, ch_rdy, ch_wb = '0, ch_csr = '0;
    logic [N*RW-1:0]   ch_rd = '0;
    logic [N*XLEN-1:0] ch_data = '0, ch_csr_val = '0;
    logic [N*AW-1:0]   ch_csr_addr = '0;
    logic [XLEN-1:0]   xn_result, csr_value;
    logic [NREG-1:0]   xn_wr_en;
    logic              reg_wr, csr_vld, busy;
    logic [RW-1:0]     rd;
    logic [AW-1:0]     csr_addr;
    logic [0:0]        grant_ch;

    int n_chk = 0, n_fail = 0;

    ent_t q [N][$];
    int   rr = 0;
    bit   e_wr, e_csr;
    bit [NREG-1:0] e_wen;
    bit [XLEN-1:0] e_res, e_val;
    bit [RW-1:0]   e_rd;
    bit [AW-1:0]   e_addr;
    int   e_g;
    int   wlog [$];

    q100_wb_arb dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .ch_vld_i(ch_vld), .ch_rdy_o(ch_rdy), .ch_wb_i(ch_wb), .ch_rd_i(ch_rd),
        .ch_data_i(ch_data), .ch_csr_i(ch_csr), .ch_csr_addr_i(ch_csr_addr), .ch_csr_val_i(ch_csr_val),
        .xn_result_o(xn_result), .xn_wr_en_o(xn_wr_en), .reg_wr_o(reg_wr), .rd_o(rd),
        .csr_vld_o(csr_vld), .csr_addr_o(csr_addr), .csr_value_o(csr_value),
        .grant_ch_o(grant_ch), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear_out();
        e_wr = 0; e_csr = 0; e_wen = '0; e_res = '0; e_val = '0; e_rd = '0; e_addr = '0; e_g = 0;
    endfunction

    task automatic drive(input int c, input bit v, input bit wb, input int r, input logic [31:0] d,
                         input bit cs, input int a, input logic [31:0] cv);
        ch_vld[c] = v; ch_wb[c] = wb; ch_rd[c*RW +: RW] = RW'(r); ch_data[c*XLEN +: XLEN] = d;
        ch_csr[c] = cs; ch_csr_addr[c*AW +: AW] = AW'(a); ch_csr_val[c*XLEN +: XLEN] = cv;
    endtask

    task automatic check_outputs();
        check("reg_wr", reg_wr, e_wr);
        check("xn_wr_en", xn_wr_en, e_wen);
        check("csr_vld", csr_vld, e_csr);
        if (e_wr) check("xn_result", xn_result, e_res);
        if (e_wr) check("rd", rd, e_rd);
        if (e_csr) check("csr_addr", csr_addr, e_addr);
        if (e_csr) check("csr_value", csr_value, e_val);
        if (e_wr || e_csr) check("grant_ch", grant_ch, e_g);
    endtask

    // One clock: check handshake/busy, advance the model across the edge, then check the outputs
    task automatic step();
        bit [N-1:0] er;
        bit eb;
        int g;
        ent_t e;
        #1;
        eb = e_wr || e_csr;
        for (int c = 0; c < N; c++) begin
            er[c] = (q[c].size() < DEPTH) && !flush;
            eb = eb || (q[c].size() > 0);
        end
        check("ch_rdy", ch_rdy, er);
        check("busy", busy, eb);
        model_clear_out();
        if (flush) begin
            for (int c = 0; c < N; c++) q[c].delete();
        end else begin
            g = -1;
            for (int k = 0; k < N && g < 0; k++)
                if (q[(rr + k) % N].size() > 0) g = (rr + k) % N;
            if (g >= 0) begin
                e = q[g].pop_front();
                e_wr = e.wb && e.rd != 0;
                e_wen = e_wr ? (NREG'(1) << e.rd) : '0;
                e_res = e.data; e_rd = e.rd; e_csr = e.csr; e_addr = e.a; e_val = e.v; e_g = g;
                rr = (g + 1) % N;
            end
            for (int c = 0; c < N; c++)
                if (ch_vld[c] && er[c])
                    q[c].push_back('{ch_wb[c], ch_rd[c*RW +: RW], ch_data[c*XLEN +: XLEN],
                                     ch_csr[c], ch_csr_addr[c*AW +: AW], ch_csr_val[c*XLEN +: XLEN]});
        end
        @(posedge clk);
        #1;
        check_outputs();
        if (reg_wr) wlog.push_back(int'(rd));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 0;
        ch_vld = '0;
        flush = 0;
        #1;
        check("rst_reg_wr", reg_wr, 0);
        check("rst_wr_en", xn_wr_en, 0);
        check("rst_csr_vld", csr_vld, 0);
        check("rst_result", xn_result, 0);
        check("rst_busy", busy, 0);
        for (int c = 0; c < N; c++) q[c].delete();
        rr = 0;
        model_clear_out();
        @(posedge clk);
        #3;
        rst_n = 1;
        #1;
        check("rst_rdy", ch_rdy, 2'b11);
        @(posedge clk);
        #1;
    endtask

    // Stream n0/n1 entries with rd base b0/b1, holding each entry until it is accepted
    task automatic stream(input int n0, input int b0, input int n1, input int b1);
        int i0 = 0, i1 = 0;
        int budget = 0;
        while ((i0 < n0 || i1 < n1) && budget < 200) begin
            drive(0, i0 < n0, 1, b0 + i0, 32'h1000 + i0, 0, 0, 0);
            drive(1, i1 < n1, 1, b1 + i1, 32'h2000 + i1, 0, 0, 0);
            #1;
            if (ch_vld[0] && (q[0].size() < DEPTH)) i0++;
            if (ch_vld[1] && (q[1].size() < DEPTH)) i1++;
            step();
            budget++;
        end
        check("stream_budget", budget < 200, 1);
        ch_vld = '0;
        for (int k = 0; k < 6; k++) step();
    endtask

    initial begin
        int exp_rr [$];
        int o0 [$];
        int o1 [$];
        model_clear_out();
        #1;
        check("init_reg_wr", reg_wr, 0);
        check("init_busy", busy, 0);
        do_reset();

        // single entry: 2-cycle latency, one-cycle pulse
        drive(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        ch_vld = '0;
        step();
        check("single_wen", xn_wr_en, 32'h20);
        check("single_data", xn_result, 32'hDEADBEEF);
        step();
        check("single_once", reg_wr, 0);

        // x0 with CSR
        drive(1, 1, 1, 0, 32'h55, 1, 12'h300, 32'h8);
        step();
        ch_vld = '0;
        step();
        check("x0_csr_vld", csr_vld, 1);
        check("x0_csr_addr", csr_addr, 12'h300);
        check("x0_wen", xn_wr_en, 0);
        step();

        // round-robin alternation
        wlog.delete();
        stream(4, 1, 4, 11);
        exp_rr = '{1, 11, 2, 12, 3, 13, 4, 14};
        check("rr_count", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) check("rr_order", wlog[i], exp_rr[i]);

        // backpressure: ch0 5 back-to-back against a busy ch1
        wlog.delete();
        stream(5, 1, 8, 16);
        foreach (wlog[i]) if (wlog[i] < 16) o0.push_back(wlog[i]); else o1.push_back(wlog[i]);
        check("bp_cnt0", o0.size(), 5);
        check("bp_cnt1", o1.size(), 8);
        for (int i = 0; i < o0.size(); i++) check("bp_order0", o0[i], 1 + i);
        for (int i = 0; i < o1.size(); i++) check("bp_order1", o1[i], 16 + i);

        // flush with entries queued on both channels
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 7, 32'h77, 0, 0, 0);
            drive(1, 1, 1, 9, 32'h99, 0, 0, 0);
            step();
        end
        flush = 1;
        step();
        flush = 0;
        ch_vld = '0;
        check("flush_busy", busy, 0);
        for (int k = 0; k < 3; k++) step();

        // randomized traffic, occasional flush and one mid-run reset
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < N; c++)
                drive(c, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31),
                      $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 4095), $urandom);
            flush = ($urandom_range(0, 31) == 0);
            step();
            if (t == 200) do_reset();
        end
        flush = 0;
        ch_vld = '0;
        for (int k = 0; k < 6; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
